// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: pipelined carry-lookahead adder/subtractor.
// The datapath is built from 4-bit lookahead blocks. Block carries ripple
// between blocks, and that chain is cut into N_STAGES register stages.
// Each stage has a valid/ready handshake with bubble collapsing.
// Optional feature: define CLA_PIPE_SAT_EN to enable unsigned saturation of y.
// When it is enabled, c_out and overflow still report the raw values.
module cla_pipe_addsub #(
  parameter int N_BLOCKS = 8,
  parameter int N_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_BLOCKS-1:0] a,
  input  logic [4*N_BLOCKS-1:0] b,
  input  logic                  c_in,
  input  logic                  sub,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*N_BLOCKS-1:0] y,
  output logic                  c_out,
  output logic                  overflow,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int N = 4 * N_BLOCKS;
  localparam int B = (N_STAGES > 0) ? (N_BLOCKS / N_STAGES) : 1;
  localparam int W = 4 * B;

  if (N_STAGES < 1 || N_STAGES > N_BLOCKS || (N_BLOCKS % N_STAGES) != 0) begin : g_paramCheck
    $error("cla_pipe_addsub: N_STAGES must be in 1..N_BLOCKS and divide N_BLOCKS");
  end

  // One 4-bit lookahead block: returns {carry out, sum}.
  // Every internal carry is formed directly from generate/propagate terms,
  // so no carry ripples inside the block.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] z, input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & z;
    p    = x ^ z;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (&p & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    localparam int LO  = k * W;
    localparam int REM = N - LO;

    logic [REM-1:0]    w_aIn;
    logic [REM-1:0]    w_bIn;
    logic              w_cIn;
    logic              w_vIn;
    logic              w_load;
    logic [B:0]        w_carry;
    logic [W-1:0]      w_sum;
    logic [LO+W-1:0]   w_sumAll;
    logic [LO+W-1:0]   w_sumNext;
    logic              r_vld;
    logic              r_c;
    logic [LO+W-1:0]   r_sum;
`ifdef CLA_PIPE_SAT_EN
    logic              w_subIn;
`endif

    // Stage 0 takes the operands from the ports. b is inverted and a
    // forced carry-in of 1 is used in subtract mode. Later stages take
    // their operands from the previous stage's registers.
    if (k == 0) begin : g_src
      assign w_aIn    = a;
      assign w_bIn    = sub ? ~b : b;
      assign w_cIn    = sub | c_in;
      assign w_vIn    = in_valid;
      assign w_sumAll = w_sum;
`ifdef CLA_PIPE_SAT_EN
      assign w_subIn  = sub;
`endif
    end else begin : g_src
      assign w_aIn    = g_stage[k-1].g_fwd.r_aRem;
      assign w_bIn    = g_stage[k-1].g_fwd.r_bRem;
      assign w_cIn    = g_stage[k-1].r_c;
      assign w_vIn    = g_stage[k-1].r_vld;
      assign w_sumAll = {w_sum, g_stage[k-1].r_sum};
`ifdef CLA_PIPE_SAT_EN
      assign w_subIn  = g_stage[k-1].g_fwd.r_sub;
`endif
    end

    // A stage may capture new contents when it is empty or when its
    // successor will take its current beat this cycle.
    if (k == N_STAGES - 1) begin : g_ready
      assign w_load = !r_vld | out_ready;
    end else begin : g_ready
      assign w_load = !r_vld | g_stage[k+1].w_load;
    end

    // Chain this stage's B lookahead blocks, using the block carries.
    always_comb begin
      w_carry    = '0;
      w_sum      = '0;
      w_carry[0] = w_cIn;
      for (int j = 0; j < B; j++) begin
        {w_carry[j+1], w_sum[4*j +: 4]} = cla4(w_aIn[4*j +: 4], w_bIn[4*j +: 4], w_carry[j]);
      end
    end

`ifdef CLA_PIPE_SAT_EN
    if (k == N_STAGES - 1) begin : g_sat
      // Clamp the final result. A carry out of an add clamps to all ones.
      // A borrow out of a subtract clamps to zero.
      always_comb begin
        w_sumNext = w_sumAll;
        if (!w_subIn && w_carry[B]) begin
          w_sumNext = '1;
        end else if (w_subIn && !w_carry[B]) begin
          w_sumNext = '0;
        end
      end
    end else begin : g_sat
      assign w_sumNext = w_sumAll;
    end
`else
    assign w_sumNext = w_sumAll;
`endif

    // Register the valid bit, the carry and the partial sum.
    // The beat holds here while the downstream stage is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld <= 1'b0;
        r_c   <= 1'b0;
        r_sum <= '0;
      end else if (w_load) begin
        r_vld <= w_vIn;
        if (w_vIn) begin
          r_c   <= w_carry[B];
          r_sum <= w_sumNext;
        end
      end
    end

    if (k < N_STAGES - 1) begin : g_fwd
      logic [REM-W-1:0] r_aRem;
      logic [REM-W-1:0] r_bRem;
`ifdef CLA_PIPE_SAT_EN
      logic             r_sub;
`endif
      // Carry the operand bits that are not yet summed to the next stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_aRem <= '0;
          r_bRem <= '0;
`ifdef CLA_PIPE_SAT_EN
          r_sub  <= 1'b0;
`endif
        end else if (w_load && w_vIn) begin
          r_aRem <= w_aIn[REM-1:W];
          r_bRem <= w_bIn[REM-1:W];
`ifdef CLA_PIPE_SAT_EN
          r_sub  <= w_subIn;
`endif
        end
      end
    end else begin : g_last
      logic r_ovf;
      logic w_ovf;
      // The carry into the MSB is recovered as sum ^ a ^ b at that bit.
      assign w_ovf = w_carry[B] ^ (w_sum[W-1] ^ w_aIn[W-1] ^ w_bIn[W-1]);
      // Register the signed overflow alongside the final result.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_load && w_vIn) begin
          r_ovf <= w_ovf;
        end
      end
    end
  end

  assign in_ready  = g_stage[0].w_load;
  assign out_valid = g_stage[N_STAGES-1].r_vld;
  assign y         = g_stage[N_STAGES-1].r_sum;
  assign c_out     = g_stage[N_STAGES-1].r_c;
  assign overflow  = g_stage[N_STAGES-1].g_last.r_ovf;

endmodule

// File: doc/cla_pipe_addsub.md
Name: cla_pipe_addsub

Overview:
- Parametrised, pipelined successor to the combinational 4-bit-block carry-lookahead adder.
- Adds an add/subtract mode, a signed-overflow flag and a valid/ready handshake on both sides.
- Carry propagation across the 4-bit CLA blocks is split over N_STAGES register stages, so wide datapaths (64+ bits) close timing.
- Sits between operand-issue logic and result consumers in the ALU datapath.

Parameters:
- N_BLOCKS, 8, number of 4-bit CLA blocks; data width N = 4*N_BLOCKS.
- N_STAGES, 2, pipeline register stages; legal range 1..N_BLOCKS; N_BLOCKS % N_STAGES == 0 is required (elaboration $error otherwise).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a  input  N  operand A.
- b  input  N  operand B.
- c_in  input  1  carry in; used in add mode only.
- sub  input  1  0 = add, 1 = subtract.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  pipeline accepts a beat this cycle.
- y  output  N  result.
- c_out  output  1  carry out (in subtract mode: 1 = no borrow).
- overflow  output  1  signed two's-complement overflow.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts a result.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Arithmetic:
  - add: {c_out,y} = a + b + c_in.
  - sub: {c_out,y} = a + ~b + 1, so y = a - b mod 2^N; c_in is ignored.
  - overflow = carry into MSB XOR carry out of MSB.
  - Per-block logic: generate/propagate lookahead; blocks chained by ripple of block carries.
- Stage partitioning:
  - Stage k (0-based) computes blocks [k*B, (k+1)*B), where B = N_BLOCKS/N_STAGES.
  - Stage k registers: its partial sum bits, the carry out of its top block, the still-unprocessed upper operand bits (b already inverted when sub=1) and a valid bit.
  - The final stage also registers overflow.
- Latency: exactly N_STAGES cycles from input handshake (in_valid & in_ready at edge t) to out_valid at edge t+N_STAGES, when there is no backpressure.
- Throughput: 1 beat/cycle.
- Handshake:
  - Stage k advances when its successor is empty or advancing; the final stage advances when !out_valid | out_ready.
  - in_ready = stage 0 empty or advancing (bubble-collapsing).
  - Beats are never dropped, duplicated or reordered.
  - y, c_out, overflow are held stable while out_valid & !out_ready.
  - in_valid with in_ready=0: beat not taken; the source must hold it.
- Full and empty:
  - Full = all stages valid with out_ready=0; in_ready=0.
  - Empty pipeline: out_valid=0 and in_ready=1.
- Simultaneous events: input accept and output drain in the same cycle on a full pipe are legal; occupancy is unchanged.
- Reset values: out_valid=0, y=0, c_out=0, overflow=0, all stage valids=0; in_ready=1 one cycle after deassert and combinationally during reset.
- Reset mid-operation: all in-flight beats are discarded immediately (asynchronous); no result emerges after reset release.
- Data registers may be left unreset internally; the outputs y, c_out and overflow must read 0 under reset.

Optional Feature:
- Macro: CLA_PIPE_SAT_EN.
- Defined, unsigned saturation on y:
  - add with c_out=1 → y = all ones.
  - sub with c_out=0 (borrow) → y = 0.
  - c_out and overflow still report the raw, unsaturated values.
  - Saturation mux is placed in the final stage; latency is unchanged.
- Undefined: y wraps modulo 2^N.
- The port list is identical either way.

Test Plan (N_BLOCKS=2, N=8, N_STAGES=2 unless noted):
- Reset:
  - rst_n low, then high → out_valid=0, y=0x00, in_ready=1.
  - Drive no beats → out_valid remains 0.
- Add boundary:
  - a=0xFF, b=0xFF, c_in=1, sub=0, accepted at cycle t → at t+2: y=0xFF, c_out=1, overflow=0.
  - With SAT_EN: y=0xFF as well.
- Overflow/sub:
  - 0x7F+0x01 → y=0x80, overflow=1, c_out=0.
  - sub 0x10-0x01 → y=0x0F, c_out=1.
  - sub 0x00-0x01 → y=0xFF, c_out=0; with SAT_EN y=0x00.
- Backpressure:
  - Stream 4 back-to-back adds (i+1, i=0..3); hold out_ready=0 for 3 cycles after the first result.
  - → in_ready falls once 2 beats are held.
  - → results 1,2,3,4 arrive in order with none lost; y stable while stalled.
- Reset mid-op: assert rst_n low while 2 beats are in flight → out_valid=0 immediately; after release no stale result appears.
- Width sweep: N_BLOCKS=16, N_STAGES ∈ {1,4,16}; 1000 random beats with random out_ready → match reference a±b±c_in; latency equals N_STAGES when unstalled.
